// File: rtl/alu_divider_if.sv
// Request/result bundle between a divider client and the alu_divider block.
// The client drives start and the operands; the divider returns results and status.
// Pure wiring: no storage, so latency and backpressure are defined by the divider.
interface alu_divider_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  // Client side: issues requests, observes results.
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero
  );

  // Divider side: accepts requests, produces results.
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/alu_divider.sv
// 16/8 unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: 16 edges after the accepting edge for done (same edge for divide-by-zero).
// No backpressure: start is accepted only in IDLE or DONE and ignored while busy.
module alu_divider (
  input  logic   clk,
  input  logic   reset_n,
  alu_divider_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Working registers: dividend shifts left and fills with quotient bits.
  logic [3:0]  r_cnt;
  logic [15:0] r_dvd;
  logic [7:0]  r_dvs;
  logic [7:0]  r_rem;

  // Architected results, touched only on entry to DONE or by reset.
  logic [15:0] r_quotient;
  logic [7:0]  r_remainder;
  logic        r_div_zero;

  logic        w_accept;
  logic        w_zero_req;
  logic        w_last;
  logic [8:0]  w_partial;
  logic        w_ge;
  logic [7:0]  w_rem_nxt;
  logic [15:0] w_dvd_nxt;
  logic        w_busy;
  logic        w_done;

  // A request is only taken while no iteration is in flight.
  always_comb begin
    w_accept   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_zero_req = (bus.divisor == 8'h00);
    w_last     = (r_state == S_RUN) && (r_cnt == 4'd15);
  end

  // One restoring step: the partial remainder is always below the divisor,
  // so the 9-bit partial stays below 2*divisor and the result fits 8 bits.
  always_comb begin
    w_partial = {r_rem, r_dvd[15]};
    w_ge      = (w_partial >= {1'b0, r_dvs});
    w_rem_nxt = w_ge ? 8'(w_partial - {1'b0, r_dvs}) : w_partial[7:0];
    w_dvd_nxt = {r_dvd[14:0], w_ge};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a zero divisor skips RUN and completes immediately.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero_req ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_zero_req ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs decode directly from state, so busy and done are exclusive.
  always_comb begin
    w_busy = (r_state == S_RUN);
    w_done = (r_state == S_DONE);
  end

  // Iteration datapath: load on accept, shift/subtract each RUN cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= 4'd0;
      r_dvd <= 16'h0000;
      r_dvs <= 8'h00;
      r_rem <= 8'h00;
    end else if (w_accept) begin
      r_cnt <= 4'd0;
      r_dvd <= bus.dividend;
      r_dvs <= bus.divisor;
      r_rem <= 8'h00;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 4'd1;
      r_dvd <= w_dvd_nxt;
      r_rem <= w_rem_nxt;
    end
  end

  // Result registers: written on the edge that enters DONE, held otherwise,
  // so a following division in RUN never disturbs the previous answer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_quotient  <= 16'h0000;
      r_remainder <= 8'h00;
      r_div_zero  <= 1'b0;
    end else if (w_accept && w_zero_req) begin
      r_quotient  <= 16'hFFFF;
      r_remainder <= bus.dividend[7:0];
      r_div_zero  <= 1'b1;
    end else if (w_last) begin
      r_quotient  <= w_dvd_nxt;
      r_remainder <= w_rem_nxt;
      r_div_zero  <= 1'b0;
    end
  end

  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.div_zero  = r_div_zero;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider: reset, arithmetic, divide-by-zero, ignored
// start, back-to-back and reset abort. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_alu_divider;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  alu_divider_if dif ();

  alu_divider dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dif.start = 1'b1;
    dif.dividend = 16'h1234;
    dif.divisor = 8'h00;
    tick(); tick();
    dif.start = 1'b0;
    n_cmp++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", dif.busy); end
    n_cmp++; if (dif.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", dif.done); end
    n_cmp++; if (dif.div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dz got %b want 0", dif.div_zero); end
    n_cmp++; if (dif.quotient !== 16'h0000) begin n_bad++; $display("FAIL reset_q got %h want 0000", dif.quotient); end
    n_cmp++; if (dif.remainder !== 8'h00) begin n_bad++; $display("FAIL reset_r got %h want 00", dif.remainder); end
    reset_n = 1'b1;
    tick();
  endtask

  // 1000 / 7 = 142 r 6, with busy/done timing checked every cycle.
  task automatic test_basic();
    dif.start = 1'b1; dif.dividend = 16'h03E8; dif.divisor = 8'h07;
    tick();
    dif.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (dif.busy !== 1'b1 || dif.done !== 1'b0) begin n_bad++; $display("FAIL basic_run_%0d busy=%b done=%b want 1/0", i, dif.busy, dif.done); end
      n_cmp++; if (dif.quotient !== 16'h0000) begin n_bad++; $display("FAIL basic_hold_%0d q=%h want 0000", i, dif.quotient); end
      if (i != 15) tick();
    end
    tick();
    n_cmp++; if (dif.done !== 1'b1 || dif.busy !== 1'b0) begin n_bad++; $display("FAIL basic_done busy=%b done=%b want 0/1", dif.busy, dif.done); end
    n_cmp++; if (dif.quotient !== 16'h008E) begin n_bad++; $display("FAIL basic_q got %h want 008E", dif.quotient); end
    n_cmp++; if (dif.remainder !== 8'h06) begin n_bad++; $display("FAIL basic_r got %h want 06", dif.remainder); end
    n_cmp++; if (dif.div_zero !== 1'b0) begin n_bad++; $display("FAIL basic_dz got %b want 0", dif.div_zero); end
    tick();
    n_cmp++; if (dif.done !== 1'b0 || dif.busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle busy=%b done=%b want 0/0", dif.busy, dif.done); end
    n_cmp++; if (dif.quotient !== 16'h008E || dif.remainder !== 8'h06) begin n_bad++; $display("FAIL basic_held q=%h r=%h want 008E/06", dif.quotient, dif.remainder); end
  endtask

  task automatic test_extremes();
    logic [15:0] dd [3];
    logic [7:0]  ds [3];
    logic [15:0] eq [3];
    logic [7:0]  er [3];
    dd[0] = 16'hFFFF; ds[0] = 8'h01; eq[0] = 16'hFFFF; er[0] = 8'h00;
    dd[1] = 16'h0005; ds[1] = 8'hFF; eq[1] = 16'h0000; er[1] = 8'h05;
    dd[2] = 16'hFFFF; ds[2] = 8'h80; eq[2] = 16'h01FF; er[2] = 8'h7F;
    for (int t = 0; t < 3; t++) begin
      dif.start = 1'b1; dif.dividend = dd[t]; dif.divisor = ds[t];
      tick();
      dif.start = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      n_cmp++; if (dif.done !== 1'b1) begin n_bad++; $display("FAIL ext%0d_done got %b want 1", t, dif.done); end
      n_cmp++; if (dif.quotient !== eq[t]) begin n_bad++; $display("FAIL ext%0d_q got %h want %h", t, dif.quotient, eq[t]); end
      n_cmp++; if (dif.remainder !== er[t]) begin n_bad++; $display("FAIL ext%0d_r got %h want %h", t, dif.remainder, er[t]); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    dif.start = 1'b1; dif.dividend = 16'h1234; dif.divisor = 8'h00;
    tick();
    dif.start = 1'b0;
    n_cmp++; if (dif.done !== 1'b1 || dif.busy !== 1'b0) begin n_bad++; $display("FAIL dz_done busy=%b done=%b want 0/1", dif.busy, dif.done); end
    n_cmp++; if (dif.quotient !== 16'hFFFF) begin n_bad++; $display("FAIL dz_q got %h want FFFF", dif.quotient); end
    n_cmp++; if (dif.remainder !== 8'h34) begin n_bad++; $display("FAIL dz_r got %h want 34", dif.remainder); end
    n_cmp++; if (dif.div_zero !== 1'b1) begin n_bad++; $display("FAIL dz_flag got %b want 1", dif.div_zero); end
    tick();
    n_cmp++; if (dif.done !== 1'b0 || dif.busy !== 1'b0 || dif.div_zero !== 1'b1) begin n_bad++; $display("FAIL dz_after busy=%b done=%b dz=%b want 0/0/1", dif.busy, dif.done, dif.div_zero); end
    dif.start = 1'b1; dif.dividend = 16'h0010; dif.divisor = 8'h04;
    tick();
    dif.start = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    n_cmp++; if (dif.done !== 1'b1) begin n_bad++; $display("FAIL dz_next_done got %b want 1", dif.done); end
    n_cmp++; if (dif.quotient !== 16'h0004 || dif.remainder !== 8'h00) begin n_bad++; $display("FAIL dz_next_qr q=%h r=%h want 0004/00", dif.quotient, dif.remainder); end
    n_cmp++; if (dif.div_zero !== 1'b0) begin n_bad++; $display("FAIL dz_next_flag got %b want 0", dif.div_zero); end
    tick();
  endtask

  // A start (with new operands) during RUN must be ignored; done pulses once.
  task automatic test_ignore_start();
    int ndone;
    int done_at;
    ndone = 0; done_at = -1;
    dif.start = 1'b1; dif.dividend = 16'h03E8; dif.divisor = 8'h07;
    tick();
    dif.start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 6) begin dif.start = 1'b1; dif.dividend = 16'hFFFF; dif.divisor = 8'h01; end
      if (k == 7) begin dif.start = 1'b0; dif.dividend = 16'h0000; dif.divisor = 8'h00; end
      tick();
      if (dif.done === 1'b1) begin ndone++; done_at = k; end
    end
    n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL ign_pulses got %0d want 1", ndone); end
    n_cmp++; if (done_at != 16) begin n_bad++; $display("FAIL ign_edge got %0d want 16", done_at); end
    n_cmp++; if (dif.quotient !== 16'h008E || dif.remainder !== 8'h06) begin n_bad++; $display("FAIL ign_qr q=%h r=%h want 008E/06", dif.quotient, dif.remainder); end
  endtask

  task automatic test_back_to_back();
    dif.start = 1'b1; dif.dividend = 16'h03E8; dif.divisor = 8'h07;
    tick();
    dif.start = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    n_cmp++; if (dif.done !== 1'b1 || dif.quotient !== 16'h008E) begin n_bad++; $display("FAIL b2b_first done=%b q=%h want 1/008E", dif.done, dif.quotient); end
    dif.start = 1'b1; dif.dividend = 16'hFFFF; dif.divisor = 8'hFF;
    tick();
    dif.start = 1'b0;
    n_cmp++; if (dif.done !== 1'b0 || dif.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_run busy=%b done=%b want 1/0", dif.busy, dif.done); end
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if (dif.quotient !== 16'h008E || dif.remainder !== 8'h06 || dif.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_hold q=%h r=%h busy=%b want 008E/06/1", dif.quotient, dif.remainder, dif.busy); end
    tick();
    n_cmp++; if (dif.done !== 1'b1) begin n_bad++; $display("FAIL b2b_done2 got %b want 1", dif.done); end
    n_cmp++; if (dif.quotient !== 16'h0101 || dif.remainder !== 8'h00) begin n_bad++; $display("FAIL b2b_qr q=%h r=%h want 0101/00", dif.quotient, dif.remainder); end
    tick();
  endtask

  task automatic test_reset_abort();
    int ndone;
    ndone = 0;
    dif.start = 1'b1; dif.dividend = 16'h03E8; dif.divisor = 8'h07;
    tick();
    dif.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_cmp++; if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin n_bad++; $display("FAIL abort_status busy=%b done=%b want 0/0", dif.busy, dif.done); end
    n_cmp++; if (dif.quotient !== 16'h0000 || dif.remainder !== 8'h00) begin n_bad++; $display("FAIL abort_qr q=%h r=%h want 0000/00", dif.quotient, dif.remainder); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dif.done === 1'b1) ndone++;
    end
    n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL abort_pulse got %0d want 0", ndone); end
    dif.start = 1'b1; dif.dividend = 16'h0005; dif.divisor = 8'hFF;
    tick();
    dif.start = 1'b0;
    n_cmp++; if (dif.busy !== 1'b1) begin n_bad++; $display("FAIL post_rst_busy got %b want 1", dif.busy); end
    for (int i = 0; i < 16; i++) tick();
    n_cmp++; if (dif.done !== 1'b1 || dif.quotient !== 16'h0000 || dif.remainder !== 8'h05) begin n_bad++; $display("FAIL post_rst_res done=%b q=%h r=%h want 1/0000/05", dif.done, dif.quotient, dif.remainder); end
    tick();
  endtask

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && dif.busy === 1'b1 && dif.done === 1'b1) begin
      n_bad++;
      $display("FAIL busy_done_overlap busy=%b done=%b want not both 1", dif.busy, dif.done);
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    dif.start = 1'b0;
    dif.dividend = 16'h0000;
    dif.divisor = 8'h00;
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
